load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage. Consumes the decoder's data_req/data_byte/data_wr/zero_extnd controls,
//  the ALU address and the rs2 store data. Issues one word-aligned access on a valid/ready
//  data-memory port and returns aligned, sign- or zero-extended load data to writeback.
//  Holds off the upstream pipeline (req_ready_o low) while an access is in flight.
// PARAMETERS
//  XLEN   32  data/address width; lane logic below is fixed for XLEN=32
// PORTS
//  clk              in   1     clock, rising edge
//  reset            in   1     asynchronous, active-high
//  req_valid_i      in   1     memory op presented (decoder data_req)
//  req_ready_o      out  1     op accepted when valid&ready
//  req_wr_i         in   1     1=store, 0=load
//  req_byte_i       in   2     00=BYTE, 01=HALF_WORD, 10=WORD, 11 treated as WORD
//  req_zero_extnd_i in   1     1=zero-extend load, 0=sign-extend
//  req_addr_i       in   XLEN  byte address from ALU
//  req_wdata_i      in   XLEN  store data (rs2)
//  req_rd_i         in   5     load destination register
//  mem_req_valid_o  out  1     memory request valid
//  mem_req_ready_i  in   1     memory accepts request
//  mem_we_o         out  1     write enable
//  mem_addr_o       out  XLEN  {addr[XLEN-1:2],2'b00}
//  mem_wstrb_o      out  4     byte strobes
//  mem_wdata_o      out  XLEN  lane-replicated store data
//  mem_rsp_valid_i  in   1     load data valid, one cycle
//  mem_rdata_i      in   XLEN  load word
//  wb_valid_o       out  1     one-cycle pulse, load result valid
//  wb_rd_o          out  5     destination register
//  wb_data_o        out  XLEN  extended load result
//  misaligned_o     out  1     one-cycle pulse, access rejected
//  busy_o           out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready_o=1; latched request cleared.
//  FSM IDLE / REQ / WAIT_RSP. req_ready_o=1 only in IDLE.
//  IDLE, accept: misaligned = (HALF & addr[0]) | (WORD & |addr[1:0]).
//    Misaligned: misaligned_o=1 next cycle, no memory access, stay IDLE.
//    Otherwise: latch addr/byte/zx/wr/rd and formatted wdata/wstrb, go REQ.
//  REQ: mem_req_valid_o=1; mem_* held stable until mem_req_ready_i.
//    Handshake on store -> IDLE (posted, no response expected).
//    Handshake on load -> WAIT_RSP.
//  WAIT_RSP: on mem_rsp_valid_i, register the result; wb_valid_o=1 for the next cycle only;
//    go IDLE. Next op may be accepted in that same cycle.
//  Store format:
//    BYTE: wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
//    HALF: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}
//    WORD: wstrb=4'b1111, wdata unchanged. mem_wstrb_o=0 on loads.
//  Load format: shifted = rdata >> (8*addr[1:0]).
//    BYTE/HALF extend bit 7/15 unless zx=1 (then zero-fill). WORD ignores zx.
//  Latency: accept C0 -> mem_req_valid_o C1 -> earliest rsp C2 -> wb_valid_o C3.
//  No timeout: stalls indefinitely while ready/rsp stay low.
//  Ignored inputs:
//    mem_rsp_valid_i outside WAIT_RSP (no wb pulse).
//    req_valid_i while busy (not accepted, no state change).
//  Reset mid-op returns to IDLE at once; any late response is dropped by the rule above.
// TESTING
//  1. LB addr=0x1003, rdata=0x80FF_1234, zx=0
//     -> mem_addr_o=0x1000, wb_data_o=0xFFFF_FF80, wb_valid_o 1 cycle.
//  2. LHU addr=0x2002, rdata=0xBEEF_0000 -> wb_data_o=0x0000_BEEF.
//  3. SB addr=0x3001, wdata=0x0000_00AB
//     -> mem_wstrb_o=4'b0010, mem_wdata_o=0xABAB_ABAB, no wb_valid_o.
//  4. SW addr=0x4002 -> misaligned_o pulse, mem_req_valid_o stays 0, req_ready_o stays 1.
//  5. LW with mem_req_ready_i low 3 cycles, then rsp delayed 2 cycles
//     -> mem_* stable throughout, req_ready_o=0 until after the response.
//  6. Reset asserted in WAIT_RSP, then rsp_valid arrives
//     -> IDLE, outputs reset values, no wb_valid_o.

Source files
------------

// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces for the load/store unit.
//
// lsu_req_if : pipeline side. The request controls come from the decoder and
//              ALU. The writeback result, the misaligned pulse and busy go back
//              to the pipeline.
//   slave  modport : the LSU's view. It receives req_*, drives req_ready_o,
//                    wb_*, misaligned_o and busy_o.
//   master modport : the pipeline's view, with every direction reversed.
//
// lsu_mem_if : data-memory side. Carries the valid/ready request channel and a
//              one-cycle load response.
//   master modport : the LSU's view. It drives mem_req_valid_o, mem_we_o,
//                    mem_addr_o, mem_wstrb_o and mem_wdata_o.
//   slave  modport : the memory's view.
// ----------------------------------------------------------------------------
interface lsu_req_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_wr_i;
    logic [1:0]      req_byte_i;
    logic            req_zero_extnd_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic [4:0]      req_rd_i;
    logic            wb_valid_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            misaligned_o;
    logic            busy_o;

    modport slave (
        input  req_valid_i, req_wr_i, req_byte_i, req_zero_extnd_i,
               req_addr_i, req_wdata_i, req_rd_i,
        output req_ready_o, wb_valid_o, wb_rd_o, wb_data_o,
               misaligned_o, busy_o
    );

    modport master (
        output req_valid_i, req_wr_i, req_byte_i, req_zero_extnd_i,
               req_addr_i, req_wdata_i, req_rd_i,
        input  req_ready_o, wb_valid_o, wb_rd_o, wb_data_o,
               misaligned_o, busy_o
    );
endinterface

interface lsu_mem_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid_o;
    logic            mem_req_ready_i;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [3:0]      mem_wstrb_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_rsp_valid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport master (
        output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit : memory stage of the pipeline.
//
// The unit accepts one load or store from the pipeline when it is idle. It
// issues a single word-aligned access on the data-memory port. For a load, it
// returns the selected byte, half-word or word, sign- or zero-extended, to
// writeback. A misaligned half-word or word access is rejected with a
// one-cycle misaligned_o pulse and never reaches memory.
//
// Ports
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high
//   req     : lsu_req_if.slave. Carries the pipeline request (valid/ready),
//             the writeback result, misaligned_o and busy_o.
//   mem     : lsu_mem_if.master. Carries the data-memory request (valid/ready)
//             and the one-cycle load response.
//
// Timing: accept C0 -> mem_req_valid_o C1 -> earliest response C2 ->
//         wb_valid_o C3. Stores are posted and the unit returns to IDLE on the
//         request handshake. There is no timeout.
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    // Latched request; it holds mem_* stable while the memory stalls.
    logic [XLEN-1:0] r_addr;
    logic            r_is_byte;
    logic            r_is_half;
    logic            r_zx;
    logic            r_wr;
    logic [4:0]      r_rd;
    logic [3:0]      r_wstrb;
    logic [XLEN-1:0] r_wdata;

    // Registered pulses and writeback result.
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_misaligned;

    logic            w_accept;
    logic            w_is_byte;
    logic            w_is_half;
    logic            w_is_word;
    logic            w_misaligned;
    logic            w_rsp_take;
    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_ld_data;

    // A size code of 2'b11 is not BYTE or HALF, so it falls through to WORD.
    assign w_is_byte    = (req.req_byte_i == 2'b00);
    assign w_is_half    = (req.req_byte_i == 2'b01);
    assign w_is_word    = !w_is_byte && !w_is_half;
    assign w_misaligned = (w_is_half && req.req_addr_i[0]) ||
                          (w_is_word && (|req.req_addr_i[1:0]));

    assign w_accept   = req.req_valid_i && (r_state == S_IDLE);
    assign w_rsp_take = (r_state == S_WAIT_RSP) && mem.mem_rsp_valid_i;

    // Store formatting: replicate the data across all lanes. The strobes
    // choose which lanes memory actually writes.
    // NOTE: every always_comb output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = req.req_wdata_i;
        if (w_is_byte) begin
            w_wstrb = 4'b0001 << req.req_addr_i[1:0];
            w_wdata = {4{req.req_wdata_i[7:0]}};
        end else if (w_is_half) begin
            w_wstrb = 4'b0011 << {req.req_addr_i[1], 1'b0};
            w_wdata = {2{req.req_wdata_i[15:0]}};
        end
        if (!req.req_wr_i) begin
            w_wstrb = 4'b0000;
        end
    end

    // Load formatting: move the addressed lane down to bit 0, then extend it.
    // A word access is aligned, so for WORD the shift is zero.
    assign w_shifted = mem.mem_rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ld_data = w_shifted;
        if (r_is_byte) begin
            w_ld_data = r_zx ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                             : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
        end else if (r_is_half) begin
            w_ld_data = r_zx ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                             : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
        end
    end

    // FSM state register.
    // NOTE: sequential blocks use non-blocking assignments only. Every register
    // then samples its inputs from before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and the outputs decoded from the state.
    always_comb begin
        w_next_state        = r_state;
        req.req_ready_o     = 1'b0;
        req.busy_o          = 1'b1;
        mem.mem_req_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                req.req_ready_o = 1'b1;
                req.busy_o      = 1'b0;
                if (w_accept && !w_misaligned) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                mem.mem_req_valid_o = 1'b1;
                if (mem.mem_req_ready_i) begin
                    // A store is posted, so no response follows.
                    w_next_state = r_wr ? S_IDLE : S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (mem.mem_rsp_valid_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers. The latched request is cleared on reset as well, so
    // mem_* read as zero after reset rather than holding stale values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_is_byte    <= 1'b0;
            r_is_half    <= 1'b0;
            r_zx         <= 1'b0;
            r_wr         <= 1'b0;
            r_rd         <= '0;
            r_wstrb      <= '0;
            r_wdata      <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept && w_misaligned;
            r_wb_valid   <= w_rsp_take;
            if (w_accept && !w_misaligned) begin
                r_addr    <= req.req_addr_i;
                r_is_byte <= w_is_byte;
                r_is_half <= w_is_half;
                r_zx      <= req.req_zero_extnd_i;
                r_wr      <= req.req_wr_i;
                r_rd      <= req.req_rd_i;
                r_wstrb   <= w_wstrb;
                r_wdata   <= w_wdata;
            end
            if (w_rsp_take) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ld_data;
            end
        end
    end

    assign mem.mem_we_o    = r_wr;
    assign mem.mem_addr_o  = {r_addr[XLEN-1:2], 2'b00};
    assign mem.mem_wstrb_o = r_wstrb;
    assign mem.mem_wdata_o = r_wdata;

    assign req.wb_valid_o   = r_wb_valid;
    assign req.wb_rd_o      = r_wb_rd;
    assign req.wb_data_o    = r_wb_data;
    assign req.misaligned_o = r_misaligned;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// Testbench for load_store_unit.
//
// The stimulus process pushes the expected memory request, writeback result
// or misaligned pulse into queues, then issues the op. A monitor running on the
// falling edge pops and compares an entry each time the DUT performs a memory
// handshake, raises wb_valid_o or raises misaligned_o. The monitor also checks
// that mem_* stay stable while the memory stalls. A responder process models
// the memory, with a programmable ready delay and response delay.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lsu_req_if #(.XLEN(32)) req_bus ();
    lsu_mem_if #(.XLEN(32)) mem_bus ();

    load_store_unit #(.XLEN(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .req   (req_bus),
        .mem   (mem_bus)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    // One directed vector, with every expected value computed by hand.
    typedef struct packed {
        logic        wr;
        logic [1:0]  sz;
        logic        zx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [3:0]  rdy_dly;
        logic [3:0]  rsp_dly;
        logic        mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_wb;
    } vec_t;

    mem_exp_t mem_q[$];
    wb_exp_t  wb_q[$];
    int       mis_exp  = 0;
    int       checks   = 0;
    int       errors   = 0;
    int       wb_seen  = 0;

    // Memory responder settings.
    logic [31:0] rsp_rdata = '0;
    int          ready_dly = 0;
    int          rsp_dly   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- memory responder ----------------
    initial begin : responder
        logic is_load;
        mem_bus.mem_req_ready_i = 1'b0;
        mem_bus.mem_rsp_valid_i = 1'b0;
        mem_bus.mem_rdata_i     = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_bus.mem_req_valid_o) begin
                for (int i = 0; i < ready_dly; i++) begin
                    @(posedge clk); #1;
                end
                mem_bus.mem_req_ready_i = 1'b1;
                is_load = !mem_bus.mem_we_o;
                @(posedge clk); #1;
                mem_bus.mem_req_ready_i = 1'b0;
                if (is_load) begin
                    for (int i = 0; i < rsp_dly; i++) begin
                        @(posedge clk); #1;
                    end
                    mem_bus.mem_rsp_valid_i = 1'b1;
                    mem_bus.mem_rdata_i     = rsp_rdata;
                    @(posedge clk); #1;
                    mem_bus.mem_rsp_valid_i = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        have_prev = 1'b0;
        logic [4:0]  prev_ctl  = '0;
        logic [31:0] prev_addr = '0;
        logic [31:0] prev_data = '0;
        mem_exp_t    me;
        wb_exp_t     we;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req_valid_o) begin
                if (have_prev) begin
                    check("stable_ctl",   32'({mem_bus.mem_we_o, mem_bus.mem_wstrb_o}), 32'(prev_ctl));
                    check("stable_addr",  mem_bus.mem_addr_o,  prev_addr);
                    check("stable_wdata", mem_bus.mem_wdata_o, prev_data);
                end
                prev_ctl  = {mem_bus.mem_we_o, mem_bus.mem_wstrb_o};
                prev_addr = mem_bus.mem_addr_o;
                prev_data = mem_bus.mem_wdata_o;
                have_prev = !mem_bus.mem_req_ready_i;
                if (mem_bus.mem_req_ready_i) begin
                    if (mem_q.size() == 0) begin
                        fail_now("unexpected_mem_req");
                    end else begin
                        me = mem_q.pop_front();
                        check("mem_we",    32'(mem_bus.mem_we_o),    32'(me.we));
                        check("mem_addr",  mem_bus.mem_addr_o,       me.addr);
                        check("mem_wstrb", 32'(mem_bus.mem_wstrb_o), 32'(me.strb));
                        if (me.we) begin
                            check("mem_wdata", mem_bus.mem_wdata_o, me.wdata);
                        end
                    end
                end
            end else begin
                have_prev = 1'b0;
            end

            if (req_bus.wb_valid_o) begin
                wb_seen++;
                if (wb_q.size() == 0) begin
                    fail_now("unexpected_wb_valid");
                end else begin
                    we = wb_q.pop_front();
                    check("wb_rd",   32'(req_bus.wb_rd_o), 32'(we.rd));
                    check("wb_data", req_bus.wb_data_o,    we.data);
                end
            end

            if (req_bus.misaligned_o) begin
                if (mis_exp == 0) begin
                    fail_now("unexpected_misaligned");
                end else begin
                    mis_exp--;
                    checks++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic wr, input logic [1:0] sz, input logic zx,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        req_bus.req_wr_i         = wr;
        req_bus.req_byte_i       = sz;
        req_bus.req_zero_extnd_i = zx;
        req_bus.req_addr_i       = addr;
        req_bus.req_wdata_i      = wdata;
        req_bus.req_rd_i         = rd;
    endtask

    // Present an op and hold it until the accepting clock edge.
    task automatic send(input logic wr, input logic [1:0] sz, input logic zx,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        drive(wr, sz, zx, addr, wdata, rd);
        req_bus.req_valid_i = 1'b1;
        while (!req_bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_bus.req_ready_o) begin
            fail_now("send_timeout");
        end
        @(posedge clk); #1;
        req_bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((wb_q.size() != 0 || mem_q.size() != 0 || mis_exp != 0 || req_bus.busy_o)
               && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            fail_now(name);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_req_ready"},  32'(req_bus.req_ready_o),     32'd1);
        check({p, "_busy"},       32'(req_bus.busy_o),          32'd0);
        check({p, "_mem_valid"},  32'(mem_bus.mem_req_valid_o), 32'd0);
        check({p, "_mem_we"},     32'(mem_bus.mem_we_o),        32'd0);
        check({p, "_mem_addr"},   mem_bus.mem_addr_o,           32'd0);
        check({p, "_mem_wstrb"},  32'(mem_bus.mem_wstrb_o),     32'd0);
        check({p, "_mem_wdata"},  mem_bus.mem_wdata_o,          32'd0);
        check({p, "_wb_valid"},   32'(req_bus.wb_valid_o),      32'd0);
        check({p, "_wb_rd"},      32'(req_bus.wb_rd_o),         32'd0);
        check({p, "_wb_data"},    req_bus.wb_data_o,            32'd0);
        check({p, "_misaligned"}, 32'(req_bus.misaligned_o),    32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        rsp_rdata = v.rdata;
        ready_dly = int'(v.rdy_dly);
        rsp_dly   = int'(v.rsp_dly);
        if (v.mis) begin
            mis_exp++;
        end else begin
            mem_q.push_back('{we: v.wr, addr: v.exp_addr, strb: v.exp_strb, wdata: v.exp_wdata});
            if (!v.wr) begin
                wb_q.push_back('{rd: v.rd, data: v.exp_wb});
            end
        end
        send(v.wr, v.sz, v.zx, v.addr, v.wdata, v.rd);
        if (v.mis) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("mis_req_ready", 32'(req_bus.req_ready_o),     32'd1);
                check("mis_mem_valid", 32'(mem_bus.mem_req_valid_o), 32'd0);
            end
        end
        wait_idle("vec_done_timeout");
    endtask

    // ---------------- directed vectors ----------------
    //                wr  sz     zx  addr          wdata         rd     rdata         rdy  rsp  mis  exp_addr      strb     exp_wdata     exp_wb
    vec_t vecs [13] = '{
        '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        5'd5,  32'h80FF_1234, 4'd0, 4'd0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80}, // LB sign
        '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        5'd6,  32'hBEEF_0000, 4'd0, 4'd0, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_BEEF}, // LHU
        '{1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00AB, 5'd0, 32'h0,         4'd0, 4'd0, 1'b0, 32'h0000_3000, 4'b0010, 32'hABAB_ABAB, 32'h0},        // SB
        '{1'b1, 2'b10, 1'b0, 32'h0000_4002, 32'h1111_2222, 5'd0, 32'h0,         4'd0, 4'd0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0},        // SW misaligned
        '{1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'h0,        5'd8,  32'h8001_0000, 4'd0, 4'd1, 1'b0, 32'h0000_6000, 4'b0000, 32'h0,        32'hFFFF_8001}, // LH sign
        '{1'b0, 2'b00, 1'b1, 32'h0000_7001, 32'h0,        5'd9,  32'h0000_C300, 4'd0, 4'd0, 1'b0, 32'h0000_7000, 4'b0000, 32'h0,        32'h0000_00C3}, // LBU
        '{1'b1, 2'b01, 1'b0, 32'h0000_8002, 32'h1234_5678, 5'd0, 32'h0,         4'd0, 4'd0, 1'b0, 32'h0000_8000, 4'b1100, 32'h5678_5678, 32'h0},        // SH upper
        '{1'b1, 2'b10, 1'b0, 32'h0000_9000, 32'hCAFE_F00D, 5'd0, 32'h0,         4'd1, 4'd0, 1'b0, 32'h0000_9000, 4'b1111, 32'hCAFE_F00D, 32'h0},        // SW
        '{1'b0, 2'b01, 1'b0, 32'h0000_A001, 32'h0,        5'd3,  32'h0,         4'd0, 4'd0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0},        // LH misaligned
        '{1'b0, 2'b11, 1'b0, 32'h0000_B000, 32'h0,        5'd10, 32'h1234_5678, 4'd0, 4'd0, 1'b0, 32'h0000_B000, 4'b0000, 32'h0,        32'h1234_5678}, // size 11 = word
        '{1'b0, 2'b10, 1'b1, 32'h0000_B004, 32'h0,        5'd11, 32'h8000_0000, 4'd0, 4'd0, 1'b0, 32'h0000_B004, 4'b0000, 32'h0,        32'h8000_0000}, // LW ignores zx
        '{1'b0, 2'b00, 1'b0, 32'h0000_C002, 32'h0,        5'd12, 32'h117F_2233, 4'd0, 4'd0, 1'b0, 32'h0000_C000, 4'b0000, 32'h0,        32'h0000_007F}, // LB positive
        '{1'b1, 2'b00, 1'b0, 32'h0000_D003, 32'hFFFF_FF5A, 5'd0, 32'h0,         4'd0, 4'd0, 1'b0, 32'h0000_D000, 4'b1000, 32'h5A5A_5A5A, 32'h0}         // SB top lane
    };

    initial begin : stimulus
        bit seen;
        int n;
        int wb_before;

        req_bus.req_valid_i = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // LW with 3 ready-stall cycles and a 2-cycle response delay. A stray
        // request pulse while busy must be ignored.
        rsp_rdata = 32'hDEAD_BEEF;
        ready_dly = 3;
        rsp_dly   = 2;
        mem_q.push_back('{we: 1'b0, addr: 32'h0000_5000, strb: 4'b0000, wdata: 32'h0});
        wb_q.push_back('{rd: 5'd7, data: 32'hDEAD_BEEF});
        send(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 5'd7);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 2) begin
                drive(1'b1, 2'b10, 1'b0, 32'h0000_F000, 32'h0BAD_0BAD, 5'd0);
                req_bus.req_valid_i = 1'b1;
            end else begin
                req_bus.req_valid_i = 1'b0;
            end
            if (req_bus.wb_valid_o) begin
                check("stall_ready_at_wb", 32'(req_bus.req_ready_o), 32'd1);
                seen = 1'b1;
            end else begin
                check("stall_ready_busy", 32'(req_bus.req_ready_o), 32'd0);
            end
        end
        req_bus.req_valid_i = 1'b0;
        if (!seen) begin
            fail_now("stall_wb_timeout");
        end
        wait_idle("stall_done_timeout");

        // Reset while in WAIT_RSP. The late response must produce no writeback.
        rsp_rdata = 32'h55AA_55AA;
        ready_dly = 0;
        rsp_dly   = 4;
        mem_q.push_back('{we: 1'b0, addr: 32'h0000_E000, strb: 4'b0000, wdata: 32'h0});
        send(1'b0, 2'b10, 1'b0, 32'h0000_E000, 32'h0, 5'd13);
        n = 0;
        while (!(req_bus.busy_o && !mem_bus.mem_req_valid_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            fail_now("reach_wait_rsp_timeout");
        end
        wb_before = wb_seen;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_wb", 32'(wb_seen), 32'(wb_before));
        check("midrst_idle",  32'(req_bus.busy_o), 32'd0);

        check("end_mem_q", 32'(mem_q.size()), 32'd0);
        check("end_wb_q",  32'(wb_q.size()),  32'd0);
        check("end_mis",   32'(mis_exp),      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
